// File: rtl/poco_pkg.sv
// -----------------------------------------------------------------------------
// poco_pkg
// Shared types and constants for the data-memory path.
//   arb_state_t : arbiter FSM state (normal priority / forced loader slot)
//   owner_t     : which requester owns the read data returning next cycle
//   LED_BASE    : base address of the memory-mapped LED register (led decode)
// -----------------------------------------------------------------------------
package poco_pkg;

    typedef enum logic [0:0] {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    localparam logic [15:0] LED_BASE = 16'hFF00;

endpackage

// File: rtl/arb_wait_ctr.sv
// -----------------------------------------------------------------------------
// arb_wait_ctr
// Saturating count of consecutive cycles the loader has been kept waiting.
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   inc      in  loader requesting and not granted this cycle
//   clr      in  loader granted or not requesting (has priority over inc)
//   at_limit out count == MAX_WAIT-1: one more denial forces a loader slot
// -----------------------------------------------------------------------------
module arb_wait_ctr #(
    parameter int MAX_WAIT = 8,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at MAX_WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (inc && (cnt_q != CW'(MAX_WAIT))) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store port and the
// loader/debug port. The CPU has priority; after MAX_WAIT consecutive denials
// the loader gets one forced slot and the CPU is stalled for that cycle.
// Read data (1-cycle synchronous memory) is steered back to its requester.
//
// Ports
//   clk, rst                      clock / synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU access request
//   cpu_rdata, cpu_stall          CPU read data (cycle after read), stall
//   ld_req/we/addr/wdata          loader request, held until ld_gnt
//   ld_gnt, ld_rvalid, ld_rdata   loader grant pulse, read data
//   mem_addr/wdata/we, mem_rdata  memory/led side
//   cnt_cpu/cnt_ld/cnt_force      grant statistics (only with
//                                 DMEM_ARB_STATS_EN defined)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import poco_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   cnt_cpu,
    output logic [15:0]   cnt_ld,
    output logic [7:0]    cnt_force,
`endif
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    owner_t     rd_owner_q;
    owner_t     rd_owner_d;
    logic       grant_cpu_s;
    logic       grant_ld_s;
    logic       at_limit_s;

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (ld_req && !grant_ld_s),
        .clr      (grant_ld_s || !ld_req),
        .at_limit (at_limit_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NORM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a forced slot lasts exactly one cycle.
    always_comb begin
        state_d = S_NORM;
        case (state_q)
            S_NORM: begin
                if (at_limit_s && ld_req && !grant_ld_s) begin
                    state_d = S_FORCE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_FORCE: state_d = S_NORM;
            default: state_d = S_NORM;
        endcase
    end

    // FSM outputs: grants and stall. Nothing is granted while in reset.
    // In a forced cycle whose loader request has gone away, the CPU is served.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_ld_s  = 1'b0;
        cpu_stall   = 1'b0;
        if (rst) begin
            grant_cpu_s = 1'b0;
        end else begin
            case (state_q)
                S_NORM: begin
                    if (cpu_req) begin
                        grant_cpu_s = 1'b1;
                    end else begin
                        grant_ld_s = ld_req;
                    end
                end
                S_FORCE: begin
                    if (ld_req) begin
                        grant_ld_s = 1'b1;
                        cpu_stall  = cpu_req;
                    end else begin
                        grant_cpu_s = cpu_req;
                    end
                end
                default: grant_cpu_s = 1'b0;
            endcase
        end
    end

    assign ld_gnt = grant_ld_s;

    // Memory-side mux; idle cycles drive zeros so the led decode sees nothing.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_we    = 1'b0;
        if (grant_cpu_s) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (grant_ld_s) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_we;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Owner of the read data that the memory returns next cycle.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (grant_cpu_s && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (grant_ld_s && !ld_we) begin
            rd_owner_d = OWN_LD;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Read-owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ld_rvalid = (rd_owner_q == OWN_LD);
    assign ld_rdata  = (rd_owner_q == OWN_LD)  ? mem_rdata : {DW{1'b0}};
    assign cpu_rdata = (rd_owner_q == OWN_CPU) ? mem_rdata : {DW{1'b0}};

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt_cpu_q;
    logic [15:0] cnt_ld_q;
    logic [7:0]  cnt_force_q;

    // Wrapping grant statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_cpu_q   <= 16'd0;
            cnt_ld_q    <= 16'd0;
            cnt_force_q <= 8'd0;
        end else begin
            cnt_cpu_q   <= cnt_cpu_q + {15'd0, grant_cpu_s};
            cnt_ld_q    <= cnt_ld_q + {15'd0, grant_ld_s};
            cnt_force_q <= cnt_force_q + {7'd0, (state_q == S_FORCE)};
        end
    end

    assign cnt_cpu   = cnt_cpu_q;
    assign cnt_ld    = cnt_ld_q;
    assign cnt_force = cnt_force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed vector table, hand-written contention sequences, then randomized
// traffic against a behavioural model of the arbitration rules. A small
// synchronous memory answers the DUT's memory port.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ld_req, ld_we;
    logic [15:0] ld_addr, ld_wdata, ld_rdata;
    logic        ld_gnt, ld_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt_cpu, cnt_ld;
    logic [7:0]  cnt_force;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
`ifdef DMEM_ARB_STATS_EN
        .cnt_cpu   (cnt_cpu),
        .cnt_ld    (cnt_ld),
        .cnt_force (cnt_force),
`endif
        .mem_rdata (mem_rdata)
    );

    // Synchronous-read memory, 16 words (address aliased on the low nibble).
    logic [15:0] bmem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) bmem[k] <= 16'h0000;
            mem_rdata <= 16'h0000;
        end else begin
            if (mem_we) bmem[mem_addr[3:0]] <= mem_wdata;
            mem_rdata <= bmem[mem_addr[3:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cr, input logic cw,
                         input logic [15:0] ca, input logic [15:0] cd,
                         input logic lr, input logic lw,
                         input logic [15:0] la, input logic [15:0] ld);
        @(negedge clk);
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ld;
        #2;
    endtask

    typedef struct {
        logic        rst, cr, cw;
        logic [15:0] ca, cd;
        logic        lr, lw;
        logic [15:0] la, ld;
        logic        e_gnt, e_stall, e_we;
        logic [15:0] e_addr, e_wd;
        logic        e_rv;
        logic [15:0] e_lrd, e_crd;
    } vec_t;

    vec_t vt [8];

    // Behavioural model state.
    bit          forced_m;
    int          run_m;      // consecutive cycles the loader was refused
    int          own_m;      // 0 none, 1 cpu, 2 loader
    logic [15:0] rval_m;
    logic [15:0] smem [16];

    task automatic model_reset();
        forced_m = 1'b0; run_m = 0; own_m = 0; rval_m = 16'h0000;
        for (int k = 0; k < 16; k++) smem[k] = 16'h0000;
    endtask

    initial begin
        bit          lp;
        logic        lw_r, r_r, cr_r, cw_r;
        logic [15:0] la_r, ld_r, ca_r, cd_r;
        logic        gc, gl, st, ewe;
        logic [15:0] ea, ewd;
        int          base_cpu, base_ld, base_force;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 16'h0; ld_wdata = 16'h0;
        repeat (2) @(posedge clk);

        // ---------------- directed table ----------------
        vt[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF,
                  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[1] = vt[0];
        vt[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF,
                  1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
        vt[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000,
                  1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'h0000};
        vt[5] = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 16'h0000};
        vt[6] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h1234};

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rst, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
                  vt[i].lr, vt[i].lw, vt[i].la, vt[i].ld);
            chk($sformatf("v%0d ld_gnt", i),    {31'd0, ld_gnt},    {31'd0, vt[i].e_gnt});
            chk($sformatf("v%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vt[i].e_stall});
            chk($sformatf("v%0d mem_we", i),    {31'd0, mem_we},    {31'd0, vt[i].e_we});
            chk($sformatf("v%0d mem_addr", i),  {16'd0, mem_addr},  {16'd0, vt[i].e_addr});
            chk($sformatf("v%0d mem_wdata", i), {16'd0, mem_wdata}, {16'd0, vt[i].e_wd});
            chk($sformatf("v%0d ld_rvalid", i), {31'd0, ld_rvalid}, {31'd0, vt[i].e_rv});
            chk($sformatf("v%0d ld_rdata", i),  {16'd0, ld_rdata},  {16'd0, vt[i].e_lrd});
            chk($sformatf("v%0d cpu_rdata", i), {16'd0, cpu_rdata}, {16'd0, vt[i].e_crd});
        end

        // ---------------- contention: 8 CPU grants, 1 forced, CPU again ----------------
        base_cpu = 0; base_ld = 0; base_force = 0;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, (i <= 9), 1'b1, 16'h0040, 16'hA5A5);
`ifdef DMEM_ARB_STATS_EN
            if (i == 1) begin
                base_cpu = int'(cnt_cpu); base_ld = int'(cnt_ld); base_force = int'(cnt_force);
            end
`endif
            chk($sformatf("cont%0d ld_gnt", i),    {31'd0, ld_gnt},    {31'd0, (i == 9)});
            chk($sformatf("cont%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, (i == 9)});
            chk($sformatf("cont%0d mem_we", i),    {31'd0, mem_we},    {31'd0, (i == 9)});
            chk($sformatf("cont%0d mem_addr", i),  {16'd0, mem_addr},
                (i == 9) ? 32'h0000_0040 : 32'h0000_0030);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef DMEM_ARB_STATS_EN
        chk("stats cnt_cpu",   int'(cnt_cpu) - base_cpu,     32'd9);
        chk("stats cnt_ld",    int'(cnt_ld) - base_ld,       32'd1);
        chk("stats cnt_force", int'(cnt_force) - base_force, 32'd1);
`endif

        // ---------------- forced cycle with the loader gone ----------------
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000);
            chk($sformatf("drop%0d ld_gnt", i), {31'd0, ld_gnt}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0, 1'b0, 16'h0050, 16'h0000);
        chk("drop ld_gnt",    {31'd0, ld_gnt},    32'd0);
        chk("drop cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("drop mem_addr",  {16'd0, mem_addr},  32'h0000_0060);
        // The wait count restarted from zero: a fresh run forces on its 9th cycle.
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000);
            chk($sformatf("rerun%0d ld_gnt", i),    {31'd0, ld_gnt},    {31'd0, (i == 9)});
            chk($sformatf("rerun%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, (i == 9)});
        end

        // ---------------- randomized traffic vs. model ----------------
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        model_reset();
        lp = 1'b0; lw_r = 1'b0; la_r = 16'h0; ld_r = 16'h0;
        for (int c = 0; c < 3000; c++) begin
            r_r  = ($urandom_range(0, 299) == 0);
            cr_r = ($urandom_range(0, 7) != 0);
            cw_r = 1'($urandom_range(0, 1));
            ca_r = 16'($urandom);
            cd_r = 16'($urandom);
            if (!lp && ($urandom_range(0, 2) == 0)) begin
                lp = 1'b1; lw_r = 1'($urandom_range(0, 1));
                la_r = 16'($urandom); ld_r = 16'($urandom);
            end else if (lp && ($urandom_range(0, 59) == 0)) begin
                lp = 1'b0;
            end
            drive(r_r, cr_r, cw_r, ca_r, cd_r, lp, lw_r, la_r, ld_r);

            // Expected grants: CPU first, unless this is the loader's forced slot.
            if (r_r) begin
                gc = 1'b0; gl = 1'b0; st = 1'b0;
            end else if (forced_m && lp) begin
                gc = 1'b0; gl = 1'b1; st = cr_r;
            end else begin
                gc = cr_r; gl = lp && !cr_r; st = 1'b0;
            end
            ewe = 1'b0; ea = 16'h0; ewd = 16'h0;
            if (gc) begin ewe = cw_r; ea = ca_r; ewd = cd_r; end
            if (gl) begin ewe = lw_r; ea = la_r; ewd = ld_r; end

            chk($sformatf("rnd%0d ld_gnt", c),    {31'd0, ld_gnt},    {31'd0, gl});
            chk($sformatf("rnd%0d cpu_stall", c), {31'd0, cpu_stall}, {31'd0, st});
            chk($sformatf("rnd%0d mem_we", c),    {31'd0, mem_we},    {31'd0, ewe});
            chk($sformatf("rnd%0d mem_addr", c),  {16'd0, mem_addr},  {16'd0, ea});
            chk($sformatf("rnd%0d mem_wdata", c), {16'd0, mem_wdata}, {16'd0, ewd});
            chk($sformatf("rnd%0d ld_rvalid", c), {31'd0, ld_rvalid}, {31'd0, (own_m == 2)});
            chk($sformatf("rnd%0d ld_rdata", c),  {16'd0, ld_rdata},
                (own_m == 2) ? {16'd0, rval_m} : 32'd0);
            chk($sformatf("rnd%0d cpu_rdata", c), {16'd0, cpu_rdata},
                (own_m == 1) ? {16'd0, rval_m} : 32'd0);

            // Advance the model to the next cycle.
            if (r_r) begin
                model_reset();
            end else begin
                own_m = 0;
                if (gc && !cw_r) begin own_m = 1; rval_m = smem[ca_r[3:0]]; end
                if (gl && !lw_r) begin own_m = 2; rval_m = smem[la_r[3:0]]; end
                if (ewe) smem[ea[3:0]] = ewd;
                run_m    = (lp && !gl) ? run_m + 1 : 0;
                forced_m = (run_m >= MW);
            end
            if (gl) lp = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
